// File: rtl/led_pattern_gen.sv
// led_pattern_gen: generates the three LED patterns (shift, shift2, flash)
// that the downstream sequence mux selects between. A programmable-rate
// prescaler produces a one-clock step tick, and all three patterns advance
// together on that tick.
//
// Optional build macro: LED_PINGPONG_EN
//   undefined : o_shift2_leds rotates one-hot toward the LSB.
//   defined   : o_shift2_leds bounces between LSB and MSB (ping-pong),
//               tracked by a one-bit direction register.
//
// Event priority at a clock edge: reset > rate change > terminal count.
// All outputs are registered.
module led_pattern_gen #(
  parameter int NB_LEDS  = 4,
  parameter int NB_COUNT = 32,
  parameter int COUNT_R0 = 2**22,
  parameter int COUNT_R1 = 2**23,
  parameter int COUNT_R2 = 2**24,
  parameter int COUNT_R3 = 2**25
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [1:0]         i_rate_sel,
  output logic [NB_LEDS-1:0] o_shift_leds,
  output logic [NB_LEDS-1:0] o_shift2_leds,
  output logic [NB_LEDS-1:0] o_flash_leds,
  output logic               o_tick
);

  localparam logic [NB_COUNT-1:0] ONE = NB_COUNT'(1);

  // A period of zero clocks has no meaning; it is treated as one clock.
  localparam logic [NB_COUNT-1:0] RAW_R0   = NB_COUNT'(COUNT_R0);
  localparam logic [NB_COUNT-1:0] RAW_R1   = NB_COUNT'(COUNT_R1);
  localparam logic [NB_COUNT-1:0] RAW_R2   = NB_COUNT'(COUNT_R2);
  localparam logic [NB_COUNT-1:0] RAW_R3   = NB_COUNT'(COUNT_R3);
  localparam logic [NB_COUNT-1:0] LIMIT_R0 = (RAW_R0 == '0) ? ONE : RAW_R0;
  localparam logic [NB_COUNT-1:0] LIMIT_R1 = (RAW_R1 == '0) ? ONE : RAW_R1;
  localparam logic [NB_COUNT-1:0] LIMIT_R2 = (RAW_R2 == '0) ? ONE : RAW_R2;
  localparam logic [NB_COUNT-1:0] LIMIT_R3 = (RAW_R3 == '0) ? ONE : RAW_R3;

  localparam logic [NB_LEDS-1:0] LSB_HOT = NB_LEDS'(1);

  // Prescaler state
  logic [NB_COUNT-1:0] count;
  logic [NB_COUNT-1:0] count_d;
  logic [1:0]          rate_sel_q;
  logic [NB_COUNT-1:0] limit;
  logic                rate_change;
  logic                terminal;
  logic                tick_d;
  logic                step;

  // Next pattern values
  logic [NB_LEDS-1:0]  shift_d;
  logic [NB_LEDS-1:0]  shift2_d;
  logic [NB_LEDS-1:0]  flash_d;
  logic [NB_LEDS-1:0]  shift2_rst;

  // Period selection; while the rate is stable rate_sel_q equals i_rate_sel,
  // and on a change the count is cleared regardless of the limit.
  always_comb begin
    limit = LIMIT_R0;
    case (rate_sel_q)
      2'd0:    limit = LIMIT_R0;
      2'd1:    limit = LIMIT_R1;
      2'd2:    limit = LIMIT_R2;
      default: limit = LIMIT_R3;
    endcase
  end

  // Prescaler next state: rate change beats terminal count; enable low holds.
  always_comb begin
    rate_change = (i_rate_sel != rate_sel_q);
    terminal    = (count == (limit - ONE));
    count_d     = count;
    tick_d      = 1'b0;
    step        = 1'b0;
    if (rate_change) begin
      count_d = '0;
    end else if (i_enable) begin
      if (terminal) begin
        count_d = '0;
        tick_d  = 1'b1;
        step    = 1'b1;
      end else begin
        count_d = count + ONE;
      end
    end
  end

  // Shift rotates toward the MSB; flash toggles between all-zeros and all-ones.
  always_comb begin
    shift_d = o_shift_leds;
    flash_d = o_flash_leds;
    if (step) begin
      shift_d = {o_shift_leds[NB_LEDS-2:0], o_shift_leds[NB_LEDS-1]};
      flash_d = ~o_flash_leds;
    end
  end

`ifdef LED_PINGPONG_EN
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t dir;
  dir_t dir_d;

  assign shift2_rst = LSB_HOT;

  // Ping-pong: move one place in the current direction and turn around as
  // soon as an end position is reached, so no position repeats at a turn.
  always_comb begin
    dir_d    = dir;
    shift2_d = o_shift2_leds;
    if (step) begin
      if (dir == DIR_UP) begin
        shift2_d = o_shift2_leds << 1;
        if (shift2_d[NB_LEDS-1]) dir_d = DIR_DOWN;
      end else begin
        shift2_d = o_shift2_leds >> 1;
        if (shift2_d[0]) dir_d = DIR_UP;
      end
    end
  end

  // Direction register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dir <= DIR_UP;
    end else begin
      dir <= dir_d;
    end
  end
`else
  assign shift2_rst = LSB_HOT << (NB_LEDS - 1);

  // Shift2 rotates toward the LSB.
  always_comb begin
    shift2_d = o_shift2_leds;
    if (step) begin
      shift2_d = {o_shift2_leds[0], o_shift2_leds[NB_LEDS-1:1]};
    end
  end
`endif

  // State registers; rate_sel_q samples the selector every cycle, reset too.
  always_ff @(posedge i_clk) begin
    rate_sel_q <= i_rate_sel;
    if (i_rst) begin
      count         <= '0;
      o_tick        <= 1'b0;
      o_shift_leds  <= LSB_HOT;
      o_shift2_leds <= shift2_rst;
      o_flash_leds  <= '0;
    end else begin
      count         <= count_d;
      o_tick        <= tick_d;
      o_shift_leds  <= shift_d;
      o_shift2_leds <= shift2_d;
      o_flash_leds  <= flash_d;
    end
  end

endmodule
